// File: rtl/pixel_line_fifo.sv
// -----------------------------------------------------------------------------
// pixel_line_fifo
//
// Pixel FIFO between the fetch/decode path and the video DAC output. The fetch
// side pushes RGB pixels through a valid/ready handshake. One pixel is popped
// per pixel strobe inside the active display window. The border colour is
// driven outside the window, while idle, and on underflow. Every frame start
// flushes the FIFO. A sticky underflow flag is kept for debug.
//
// Ports:
//   clk            system clock (shared with the timing generator)
//   reset_n        asynchronous active-low reset
//   wr_valid       fetch side offers wr_data
//   wr_ready       FIFO accepts wr_data this cycle (combinational)
//   wr_data        pixel to push, RGB888 {R,G,B}
//   new_pixel      one-cycle pixel strobe
//   new_frame      one-cycle pulse at the frame origin
//   h_active       horizontal display window
//   v_active       vertical display window
//   border_color   colour driven when no FIFO pixel is displayed
//   pix_data       registered output pixel
//   pix_valid      pix_data holds a FIFO pixel this cycle
//   level          current fill count, 0..DEPTH
//   underflow      sticky flag: pop requested while empty in RUN
//   clr_underflow  synchronous clear of underflow
// -----------------------------------------------------------------------------
module pixel_line_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     new_pixel,
  input  logic                     new_frame,
  input  logic                     h_active,
  input  logic                     v_active,
  input  logic [DATA_W-1:0]        border_color,
  output logic [DATA_W-1:0]        pix_data,
  output logic                     pix_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underflow,
  input  logic                     clr_underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DATA_W-1:0] pix_data_q, pix_data_d;
  logic              pix_valid_q, pix_valid_d;
  logic              underflow_q, underflow_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic run;
  logic flush;
  logic in_window;
  logic fifo_empty;
  logic fifo_full;
  logic pop_req;
  logic push;
  logic pop;
  logic empty_pop;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. RUN is left only through reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (new_frame) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    run        = (state_q == RUN);
    flush      = run && new_frame;
    in_window  = h_active && v_active;
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == FULL_LVL);
    // The flush cycle blocks both sides so it cannot race a pointer update.
    wr_ready   = run && !fifo_full && !new_frame;
    pop_req    = run && new_pixel && in_window && !new_frame;
    push       = wr_valid && wr_ready;
    pop        = pop_req && !fifo_empty;
    empty_pop  = pop_req && fifo_empty;
  end

  // ---------------------------------------------------------------------------
  // Pointers and fill level
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output pixel and sticky underflow
  // ---------------------------------------------------------------------------
  always_comb begin
    pix_valid_d = 1'b0;
    pix_data_d  = pix_data_q;
    if (pop) begin
      pix_data_d  = mem_q[rd_ptr_q];
      pix_valid_d = 1'b1;
    end else if (!run || flush || empty_pop || !in_window) begin
      pix_data_d = border_color;
    end
    // A new underflow wins over a clear in the same cycle.
    if (empty_pop) begin
      underflow_d = 1'b1;
    end else if (clr_underflow) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
  assign level     = level_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_pixel_line_fifo.sv
module tb_pixel_line_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 24;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          new_pixel;
  logic          new_frame;
  logic          h_active;
  logic          v_active;
  logic [DW-1:0] border_color;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic [LW-1:0] level;
  logic          underflow;
  logic          clr_underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: frame-running flag, a queue of stored pixels, and the
  // expected registered outputs.
  bit            m_run;
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_pix;
  bit            m_pixv;
  bit            m_uf;

  always #5 clk = ~clk;

  pixel_line_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(DW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .new_pixel    (new_pixel),
    .new_frame    (new_frame),
    .h_active     (h_active),
    .v_active     (v_active),
    .border_color (border_color),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .level        (level),
    .underflow    (underflow),
    .clr_underflow(clr_underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input bit wv, input logic [DW-1:0] wd, input bit np,
                        input bit nf, input bit h, input bit v);
    wr_valid  = wv;
    wr_data   = wd;
    new_pixel = np;
    new_frame = nf;
    h_active  = h;
    v_active  = v;
  endtask

  // Called just after a falling edge with inputs already driven. Checks the
  // combinational ready, advances the model by one clock, checks registered
  // outputs after the rising edge and returns on the next falling edge.
  task automatic tick();
    bit exp_ready;
    bit push;
    bit win;
    bit set_uf;
    exp_ready = m_run && (m_q.size() < DEPTH) && !new_frame;
    #1;
    check("wr_ready", wr_ready, exp_ready);
    push   = wr_valid && exp_ready;
    win    = h_active && v_active;
    set_uf = 1'b0;
    if (!m_run) begin
      m_pixv = 1'b0;
      m_pix  = border_color;
      if (new_frame) m_run = 1'b1;
    end else if (new_frame) begin
      m_q.delete();
      m_pixv = 1'b0;
      m_pix  = border_color;
    end else begin
      if (new_pixel && win && m_q.size() > 0) begin
        m_pix  = m_q.pop_front();
        m_pixv = 1'b1;
      end else if (new_pixel && win) begin
        m_pix  = border_color;
        m_pixv = 1'b0;
        set_uf = 1'b1;
      end else begin
        m_pixv = 1'b0;
        if (!win) m_pix = border_color;
      end
      if (push) m_q.push_back(wr_data);
    end
    if (clr_underflow) m_uf = 1'b0;
    if (set_uf)        m_uf = 1'b1;
    @(posedge clk);
    #1;
    check("pix_data",  pix_data,  m_pix);
    check("pix_valid", pix_valid, m_pixv);
    check("level",     level,     m_q.size());
    check("underflow", underflow, m_uf);
    @(negedge clk);
  endtask

  // Asserts reset away from any clock edge and checks the immediate effect.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    m_run = 1'b0;
    m_q.delete();
    m_pix  = '0;
    m_pixv = 1'b0;
    m_uf   = 1'b0;
    check("rst_level",   level,     0);
    check("rst_ready",   wr_ready,  0);
    check("rst_pixdata", pix_data,  0);
    check("rst_pixv",    pix_valid, 0);
    check("rst_uf",      underflow, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n       = 1'b0;
    clr_underflow = 1'b0;
    border_color  = 24'hABCDEF;
    set_in(0, '0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset();

    // Idle: no writes accepted, strobe in window gives border without underflow.
    set_in(1, 24'h010203, 0, 0, 1, 1); tick();
    set_in(1, 24'h010203, 1, 0, 1, 1); tick();
    check("idle_no_uf", underflow, 0);

    // Frame start, two pushes, two strobes.
    set_in(0, '0, 0, 1, 0, 0);              tick();
    set_in(1, 24'h112233, 0, 0, 0, 0);      tick();
    set_in(1, 24'h445566, 0, 0, 0, 0);      tick();
    check("lvl2", level, 2);
    set_in(0, '0, 1, 0, 1, 1);              tick();
    check("pix1", pix_data, 24'h112233);
    check("lvl1", level, 1);
    set_in(0, '0, 0, 0, 1, 1);              tick();
    check("hold", pix_data, 24'h112233);
    set_in(0, '0, 1, 0, 1, 1);              tick();
    check("pix2", pix_data, 24'h445566);
    check("lvl0", level, 0);

    // Fill to full with valid held high, then free one slot.
    for (int i = 0; i < 18; i++) begin
      set_in(1, DW'($urandom), 0, 0, 1, 1); tick();
    end
    check("full_lvl", level, DEPTH);
    set_in(1, 24'h777777, 1, 0, 1, 1); tick();
    set_in(1, 24'h777777, 0, 0, 1, 1); tick();
    check("refill_lvl", level, DEPTH);

    // Drain and underflow.
    for (int i = 0; i < 16; i++) begin
      set_in(0, '0, 1, 0, 1, 1); tick();
    end
    border_color = 24'h0000FF;
    set_in(0, '0, 1, 0, 1, 1); tick();
    check("uf_pix", pix_data, 24'h0000FF);
    check("uf_set", underflow, 1);
    set_in(0, '0, 0, 0, 1, 1); tick();
    clr_underflow = 1'b1;
    set_in(0, '0, 1, 0, 1, 1); tick();
    check("uf_set_wins", underflow, 1);
    set_in(0, '0, 0, 0, 1, 1); tick();
    check("uf_cleared", underflow, 0);
    clr_underflow = 1'b0;

    // Flush with simultaneous push and strobe.
    for (int i = 0; i < 5; i++) begin
      set_in(1, DW'($urandom), 0, 0, 0, 1); tick();
    end
    set_in(1, 24'h999999, 1, 1, 1, 1); tick();
    check("flush_lvl", level, 0);
    check("flush_uf", underflow, 0);

    // Strobe outside the window.
    for (int i = 0; i < 3; i++) begin
      set_in(1, DW'($urandom), 0, 0, 1, 1); tick();
    end
    set_in(0, '0, 1, 0, 0, 1); tick();
    check("nowin_lvl", level, 3);

    // Reset mid-stream with level 7.
    for (int i = 0; i < 4; i++) begin
      set_in(1, DW'($urandom), 0, 0, 1, 1); tick();
    end
    check("pre_rst_lvl", level, 7);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, DW'($urandom), 1, 0, 1, 1); tick();
    end
    set_in(0, '0, 0, 1, 0, 0); tick();

    // Randomized traffic with varying write pressure.
    for (int ph = 0; ph < 6; ph++) begin
      int unsigned wp;
      wp = 30 + 13 * ph;
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(99) < 10) border_color = DW'($urandom);
        clr_underflow = ($urandom_range(99) < 5);
        set_in($urandom_range(99) < wp, DW'($urandom),
               $urandom_range(99) < 45, $urandom_range(99) < 2,
               $urandom_range(99) < 80, $urandom_range(99) < 90);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
